// File: rtl/core_mem_pkg.sv
// Shared types and helpers for the core memory arbiter and its FIFO.
package core_mem_pkg;

  typedef enum logic {
    ARB_ROUND_ROBIN    = 1'b0,
    ARB_FIXED_PRIORITY = 1'b1
  } arb_mode_e;

  localparam int MEM_ADDR_W = 21;
  localparam int MEM_DATA_W = 64;

  // Default-geometry request record; the arbiter redeclares it at its own widths.
  typedef struct packed {
    logic                  write;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] wdata;
  } mem_req_t;

  function automatic int port_id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/core_memory_arbiter_fifo.sv
// In-order FIFO of granted port ids; push and pop in the same cycle are legal even when full.
module port_id_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 1,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap explicitly so non-power-of-two depths work.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/core_memory_arbiter.sv
// N-port arbiter in front of the single memory bus port: grant, hold one request,
// track in-order outstanding transactions and route each response to its requester.
module core_memory_arbiter
  import core_mem_pkg::*;
#(
  parameter int NUM_PORTS       = 2,
  parameter int ADDR_W          = 21,
  parameter int DATA_W          = 64,
  parameter int MAX_OUTSTANDING = 4,
  parameter int ARB_MODE        = 0
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_PORTS-1:0]                 req_valid,
  output logic [NUM_PORTS-1:0]                 req_ready,
  input  logic [NUM_PORTS-1:0]                 req_write,
  input  logic [NUM_PORTS*ADDR_W-1:0]          req_addr,
  input  logic [NUM_PORTS*DATA_W-1:0]          req_wdata,
  output logic                                 mem_req_valid,
  input  logic                                 mem_req_ready,
  output logic                                 mem_write,
  output logic [ADDR_W-1:0]                    mem_addr,
  output logic [DATA_W-1:0]                    mem_wdata,
  input  logic                                 mem_rsp_valid,
  input  logic [DATA_W-1:0]                    mem_rdata,
  output logic [NUM_PORTS-1:0]                 rsp_valid,
  output logic [DATA_W-1:0]                    rsp_data,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
  output logic                                 err_sticky
);

  localparam int        PORT_ID_W = port_id_w(NUM_PORTS);
  localparam int        CNT_W     = $clog2(MAX_OUTSTANDING + 1);
  localparam arb_mode_e MODE      = arb_mode_e'(ARB_MODE);

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  logic [PORT_ID_W-1:0] rr_ptr;
  logic [PORT_ID_W-1:0] grant_id;
  logic                 grant_any;
  logic                 can_accept;
  logic                 transfer;
  logic                 pop;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic [PORT_ID_W-1:0] head_id;
  req_t                 req_sel;
  req_t                 req_q;

  assign pop        = mem_rsp_valid && !fifo_empty;
  assign can_accept = (!mem_req_valid || mem_req_ready) && (!fifo_full || pop);

  always_comb begin
    int idx;
    grant_any = 1'b0;
    grant_id  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx = (MODE == ARB_ROUND_ROBIN) ? int'(rr_ptr) + i : i;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      if (!grant_any && req_valid[idx]) begin
        grant_any = 1'b1;
        grant_id  = PORT_ID_W'(idx);
      end
    end
  end

  // rst_n gates the handshake so nothing is accepted while reset is held.
  assign transfer  = grant_any && can_accept && rst_n;
  assign req_ready = transfer ? (NUM_PORTS'(1) << grant_id) : '0;

  assign req_sel.write = req_write[grant_id];
  assign req_sel.addr  = req_addr[int'(grant_id)*ADDR_W +: ADDR_W];
  assign req_sel.wdata = req_wdata[int'(grant_id)*DATA_W +: DATA_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req_valid <= 1'b0;
      req_q         <= '0;
      rr_ptr        <= '0;
      err_sticky    <= 1'b0;
    end else begin
      if (transfer) begin
        mem_req_valid <= 1'b1;
        req_q         <= req_sel;
        if (MODE == ARB_ROUND_ROBIN)
          rr_ptr <= (grant_id == PORT_ID_W'(NUM_PORTS - 1)) ? '0 : grant_id + 1'b1;
      end else if (mem_req_ready) begin
        mem_req_valid <= 1'b0;
      end
      if (mem_rsp_valid && fifo_empty) err_sticky <= 1'b1;
    end
  end

  assign mem_write = req_q.write;
  assign mem_addr  = req_q.addr;
  assign mem_wdata = req_q.wdata;

  port_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (PORT_ID_W),
    .CNT_W (CNT_W)
  ) u_order_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (transfer),
    .din   (grant_id),
    .pop   (pop),
    .dout  (head_id),
    .count (outstanding),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign rsp_valid = pop ? (NUM_PORTS'(1) << head_id) : '0;
  assign rsp_data  = mem_rdata;

endmodule

// File: tb/tb_core_memory_arbiter.sv
// Directed bench: a round-robin and a fixed-priority instance, three ports, depth four.
module tb_core_memory_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Round-robin instance
  logic [2:0]   r_req_valid = '0, r_req_ready, r_req_write = '0;
  logic [20:0]  p_addr [3];
  logic [62:0]  r_req_addr;
  logic [191:0] r_req_wdata;
  logic         r_mem_req_valid, r_mem_req_ready = 1'b1, r_mem_write;
  logic [20:0]  r_mem_addr;
  logic [63:0]  r_mem_wdata, r_mem_rdata = '0, r_rsp_data;
  logic         r_mem_rsp_valid = 1'b0, r_err;
  logic [2:0]   r_rsp_valid, r_out;

  assign r_req_addr  = {p_addr[2], p_addr[1], p_addr[0]};
  assign r_req_wdata = {64'h2222, 64'h1111, 64'h0000};

  core_memory_arbiter #(.NUM_PORTS(3), .ADDR_W(21), .DATA_W(64),
                        .MAX_OUTSTANDING(4), .ARB_MODE(0)) dut_rr (
    .clk(clk), .rst_n(rst_n),
    .req_valid(r_req_valid), .req_ready(r_req_ready), .req_write(r_req_write),
    .req_addr(r_req_addr), .req_wdata(r_req_wdata),
    .mem_req_valid(r_mem_req_valid), .mem_req_ready(r_mem_req_ready),
    .mem_write(r_mem_write), .mem_addr(r_mem_addr), .mem_wdata(r_mem_wdata),
    .mem_rsp_valid(r_mem_rsp_valid), .mem_rdata(r_mem_rdata),
    .rsp_valid(r_rsp_valid), .rsp_data(r_rsp_data),
    .outstanding(r_out), .err_sticky(r_err)
  );

  // Fixed-priority instance
  logic [2:0]   f_req_valid = '0, f_req_ready;
  logic         f_mem_req_valid, f_mem_write, f_mem_rsp_valid = 1'b0, f_err;
  logic [20:0]  f_mem_addr;
  logic [63:0]  f_mem_wdata, f_rsp_data;
  logic [2:0]   f_rsp_valid, f_out;

  core_memory_arbiter #(.NUM_PORTS(3), .ADDR_W(21), .DATA_W(64),
                        .MAX_OUTSTANDING(4), .ARB_MODE(1)) dut_fx (
    .clk(clk), .rst_n(rst_n),
    .req_valid(f_req_valid), .req_ready(f_req_ready), .req_write(3'b000),
    .req_addr(63'd0), .req_wdata(192'd0),
    .mem_req_valid(f_mem_req_valid), .mem_req_ready(1'b1),
    .mem_write(f_mem_write), .mem_addr(f_mem_addr), .mem_wdata(f_mem_wdata),
    .mem_rsp_valid(f_mem_rsp_valid), .mem_rdata(64'd0),
    .rsp_valid(f_rsp_valid), .rsp_data(f_rsp_data),
    .outstanding(f_out), .err_sticky(f_err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    r_req_valid = '0; r_req_write = '0; r_mem_rsp_valid = 1'b0; r_mem_req_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [2:0]  valid;
    logic        rsp;
    logic [2:0]  exp_ready;
    logic [2:0]  exp_rsp;
    logic [20:0] exp_addr;
  } rr_vec_t;

  typedef struct {
    logic [2:0] valid;
    logic [2:0] exp_ready;
  } fx_vec_t;

  rr_vec_t rr_tab [7];
  fx_vec_t fx_tab [7];

  initial begin
    rr_tab[0] = '{3'b111, 1'b0, 3'b001, 3'b000, 21'h0};
    rr_tab[1] = '{3'b111, 1'b1, 3'b010, 3'b001, 21'h100};
    rr_tab[2] = '{3'b111, 1'b1, 3'b100, 3'b010, 21'h101};
    rr_tab[3] = '{3'b111, 1'b1, 3'b001, 3'b100, 21'h102};
    rr_tab[4] = '{3'b111, 1'b1, 3'b010, 3'b001, 21'h100};
    rr_tab[5] = '{3'b111, 1'b1, 3'b100, 3'b010, 21'h101};
    rr_tab[6] = '{3'b000, 1'b1, 3'b000, 3'b100, 21'h102};

    fx_tab[0] = '{3'b101, 3'b001};
    fx_tab[1] = '{3'b101, 3'b001};
    fx_tab[2] = '{3'b100, 3'b100};
    fx_tab[3] = '{3'b111, 3'b001};
    fx_tab[4] = '{3'b110, 3'b010};
    fx_tab[5] = '{3'b000, 3'b000};
    fx_tab[6] = '{3'b100, 3'b100};

    p_addr[0] = 21'h100; p_addr[1] = 21'h101; p_addr[2] = 21'h102;

    // Reset held: nothing visible even with all ports requesting
    r_req_valid = 3'b111;
    #2;
    chk("reset_mem_req_valid", 64'(r_mem_req_valid), 64'd0);
    chk("reset_outstanding", 64'(r_out), 64'd0);
    chk("reset_req_ready", 64'(r_req_ready), 64'd0);
    chk("reset_err_sticky", 64'(r_err), 64'd0);
    do_reset();

    // Round-robin fairness, one grant per cycle
    for (int k = 0; k < 7; k++) begin
      r_req_valid = rr_tab[k].valid;
      r_mem_rsp_valid = rr_tab[k].rsp;
      #1;
      chk($sformatf("rr_ready[%0d]", k), 64'(r_req_ready), 64'(rr_tab[k].exp_ready));
      chk($sformatf("rr_rsp[%0d]", k), 64'(r_rsp_valid), 64'(rr_tab[k].exp_rsp));
      if (k > 0) chk($sformatf("rr_addr[%0d]", k), 64'(r_mem_addr), 64'(rr_tab[k].exp_addr));
      @(negedge clk);
    end
    r_mem_rsp_valid = 1'b0;
    #1;
    chk("rr_drained_outstanding", 64'(r_out), 64'd0);
    chk("rr_drained_mem_req_valid", 64'(r_mem_req_valid), 64'd0);
    chk("rr_no_err", 64'(r_err), 64'd0);

    // Outstanding limit and same-cycle pop/push at full
    do_reset();
    r_req_valid = 3'b001;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("lim_ready[%0d]", i), 64'(r_req_ready), 64'd1);
      @(negedge clk);
      chk($sformatf("lim_out[%0d]", i), 64'(r_out), 64'(i + 1));
    end
    #1;
    chk("lim_full_ready", 64'(r_req_ready), 64'd0);
    @(negedge clk);
    r_mem_rsp_valid = 1'b1;
    #1;
    chk("lim_pop_push_ready", 64'(r_req_ready), 64'd1);
    chk("lim_pop_rsp", 64'(r_rsp_valid), 64'd1);
    @(negedge clk);
    chk("lim_pop_push_out", 64'(r_out), 64'd4);
    r_req_valid = '0;
    repeat (4) @(negedge clk);
    r_mem_rsp_valid = 1'b0;
    chk("lim_drained_out", 64'(r_out), 64'd0);
    chk("lim_drained_err", 64'(r_err), 64'd0);

    // Downstream stall holds the registered request
    do_reset();
    p_addr[2] = 21'h1F000;
    r_mem_req_ready = 1'b0;
    r_req_valid = 3'b100;
    #1;
    chk("stall_first_ready", 64'(r_req_ready), 64'b100);
    @(negedge clk);
    r_req_valid = 3'b011;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("stall_ready[%0d]", i), 64'(r_req_ready), 64'd0);
      chk($sformatf("stall_addr[%0d]", i), 64'(r_mem_addr), 64'h1F000);
      chk($sformatf("stall_valid[%0d]", i), 64'(r_mem_req_valid), 64'd1);
      @(negedge clk);
    end
    r_mem_req_ready = 1'b1;
    #1;
    chk("stall_release_ready", 64'(r_req_ready), 64'b001);
    @(negedge clk);
    chk("stall_release_addr", 64'(r_mem_addr), 64'h100);

    // Response routing and error on an unmatched response
    do_reset();
    p_addr[0] = 21'h00CD0; p_addr[1] = 21'h00AB1;
    r_req_valid = 3'b010;
    #1;
    chk("route_p1_ready", 64'(r_req_ready), 64'b010);
    @(negedge clk);
    r_req_valid = 3'b001; r_req_write = 3'b001;
    #1;
    chk("route_p0_ready", 64'(r_req_ready), 64'b001);
    @(negedge clk);
    r_req_valid = '0; r_req_write = '0;
    chk("route_mem_write", 64'(r_mem_write), 64'd1);
    chk("route_mem_addr", 64'(r_mem_addr), 64'h00CD0);
    chk("route_outstanding", 64'(r_out), 64'd2);
    r_mem_rsp_valid = 1'b1; r_mem_rdata = 64'hDEAD_BEEF;
    #1;
    chk("route_rsp1", 64'(r_rsp_valid), 64'b010);
    chk("route_rsp1_data", r_rsp_data, 64'hDEAD_BEEF);
    @(negedge clk);
    r_mem_rdata = 64'h1234;
    #1;
    chk("route_rsp0", 64'(r_rsp_valid), 64'b001);
    chk("route_rsp0_data", r_rsp_data, 64'h1234);
    @(negedge clk);
    #1;
    chk("route_extra_rsp", 64'(r_rsp_valid), 64'd0);
    chk("route_err_before", 64'(r_err), 64'd0);
    @(negedge clk);
    r_mem_rsp_valid = 1'b0;
    chk("route_err_sticky", 64'(r_err), 64'd1);
    @(negedge clk);
    chk("route_err_holds", 64'(r_err), 64'd1);

    // Asynchronous reset in the middle of a cycle
    r_mem_req_ready = 1'b0;
    r_req_valid = 3'b001;
    @(posedge clk);
    #1;
    chk("midrst_pre_valid", 64'(r_mem_req_valid), 64'd1);
    chk("midrst_pre_out", 64'(r_out), 64'd1);
    #2;
    rst_n = 1'b0;
    r_mem_rsp_valid = 1'b1;
    r_req_valid = 3'b111;
    #1;
    chk("midrst_mem_req_valid", 64'(r_mem_req_valid), 64'd0);
    chk("midrst_outstanding", 64'(r_out), 64'd0);
    chk("midrst_err_sticky", 64'(r_err), 64'd0);
    chk("midrst_rsp_valid", 64'(r_rsp_valid), 64'd0);
    chk("midrst_req_ready", 64'(r_req_ready), 64'd0);
    do_reset();

    // Fixed priority: port 0 wins whenever it requests
    for (int k = 0; k < 7; k++) begin
      f_req_valid = fx_tab[k].valid;
      f_mem_rsp_valid = 1'b1;
      #1;
      chk($sformatf("fx_ready[%0d]", k), 64'(f_req_ready), 64'(fx_tab[k].exp_ready));
      @(negedge clk);
    end
    f_req_valid = '0;
    f_mem_rsp_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
